// File: rtl/posi_intra_mode_dec_pkg.sv
// rtl/posi_intra_mode_dec_pkg.sv - shared size/mode constants, FSM states and Z-order helpers
package posi_intra_mode_dec_pkg;

    localparam logic [1:0] SIZE_04 = 2'd0;
    localparam logic [1:0] SIZE_08 = 2'd1;
    localparam logic [1:0] SIZE_16 = 2'd2;
    localparam logic [1:0] SIZE_32 = 2'd3;

    localparam logic [5:0] INVALID_MODE = 6'b111111;
    localparam logic [5:0] MODE_PLANAR  = 6'd0;
    localparam logic [5:0] MODE_DC      = 6'd1;
    localparam logic [5:0] MODE_VER     = 6'd26;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CAND = 3'd1,
        ST_SORT = 3'd2,
        ST_ADJ  = 3'd3,
        ST_OUT  = 3'd4
    } state_t;

    // Z-order index de-interleave: even bits are x, odd bits are y
    function automatic logic [3:0] pos_x4(input logic [7:0] pos);
        return {pos[6], pos[4], pos[2], pos[0]};
    endfunction

    function automatic logic [3:0] pos_y4(input logic [7:0] pos);
        return {pos[7], pos[5], pos[3], pos[1]};
    endfunction

    function automatic logic [4:0] size_n(input logic [1:0] size);
        logic [4:0] n;
        case (size)
            SIZE_04: n = 5'd1;
            SIZE_08: n = 5'd2;
            SIZE_16: n = 5'd4;
            SIZE_32: n = 5'd8;
            default: n = 5'd1;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/posi_mpm_derive.sv
// rtl/posi_mpm_derive.sv - combinational three-candidate MPM list from left/top neighbour modes
module posi_mpm_derive
    import posi_intra_mode_dec_pkg::*;
(
    input  logic [5:0] i_mode_a,
    input  logic [5:0] i_mode_b,
    output logic [5:0] o_cand0,
    output logic [5:0] o_cand1,
    output logic [5:0] o_cand2
);

    // Angular neighbours of A, wrapped within the 32 angular directions
    logic [4:0] w_prev;
    logic [4:0] w_next;

    assign w_prev = i_mode_a[4:0] + 5'd29;
    assign w_next = i_mode_a[4:0] - 5'd1;

    always_comb begin
        o_cand0 = i_mode_a;
        o_cand1 = i_mode_b;
        o_cand2 = MODE_PLANAR;
        if (i_mode_a == i_mode_b) begin
            if (i_mode_a < 6'd2) begin
                o_cand0 = MODE_PLANAR;
                o_cand1 = MODE_DC;
                o_cand2 = MODE_VER;
            end else begin
                o_cand1 = 6'd2 + {1'b0, w_prev};
                o_cand2 = 6'd2 + {1'b0, w_next};
            end
        end else if (i_mode_a != MODE_PLANAR && i_mode_b != MODE_PLANAR) begin
            o_cand2 = MODE_PLANAR;
        end else if (i_mode_a != MODE_DC && i_mode_b != MODE_DC) begin
            o_cand2 = MODE_DC;
        end else begin
            o_cand2 = MODE_VER;
        end
    end

endmodule

// File: rtl/posi_intra_mode_dec.sv
// rtl/posi_intra_mode_dec.sv - intra luma mode decoder: MPM syntax to 35-way mode with LCU neighbour buffers
module posi_intra_mode_dec
    import posi_intra_mode_dec_pkg::*;
(
    input  logic       clk,
    input  logic       rstn,
    input  logic       start_i,
    input  logic       val_i,
    output logic       rdy_o,
    input  logic [1:0] size_i,
    input  logic [7:0] position_i,
    input  logic       mpm_flag_i,
    input  logic [1:0] mpm_idx_i,
    input  logic [4:0] rem_mode_i,
    output logic       val_o,
    input  logic       rdy_i,
    output logic [5:0] mode_o,
    output logic [1:0] size_o,
    output logic [7:0] position_o
);

    state_t     r_state;
    state_t     w_state_nxt;

    logic [1:0] r_size;
    logic [7:0] r_pos;
    logic       r_flag;
    logic [1:0] r_idx;
    logic [4:0] r_rem;
    logic [5:0] r_cand0, r_cand1, r_cand2;
    logic [5:0] r_s0, r_s1, r_s2;
    logic [5:0] r_mode;
    logic [5:0] r_top_buf [16];
    logic [5:0] r_lft_buf [16];

    logic       w_accept;
    logic       w_release;
    logic       w_clear;
    logic [3:0] w_x4, w_y4;
    logic [4:0] w_n;
    logic [15:0] w_in_x, w_in_y;
    logic [5:0] w_a_raw, w_b_raw, w_a, w_b;
    logic [5:0] w_cand0, w_cand1, w_cand2;
    logic [5:0] w_lo, w_hi;
    logic [5:0] w_s0, w_s1, w_s2;
    logic [5:0] w_m0, w_m1, w_m2, w_m3;
    logic [5:0] w_sel;
    logic [5:0] w_mode_dec;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        rdy_o       = 1'b0;
        val_o       = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                rdy_o = 1'b1;
                if (val_i) begin
                    w_state_nxt = ST_CAND;
                end
            end
            ST_CAND: w_state_nxt = ST_SORT;
            ST_SORT: w_state_nxt = ST_ADJ;
            ST_ADJ:  w_state_nxt = ST_OUT;
            ST_OUT: begin
                val_o = 1'b1;
                if (rdy_i) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_accept  = val_i & rdy_o;
    assign w_release = val_o & rdy_i;
    assign w_clear   = start_i & rdy_o;

    assign w_x4 = pos_x4(r_pos);
    assign w_y4 = pos_y4(r_pos);
    assign w_n  = size_n(r_size);

    // Neighbours on the LCU's left/top edge come from outside this LCU and count as unavailable
    assign w_a_raw = (w_x4 != 4'd0) ? r_lft_buf[w_y4] : INVALID_MODE;
    assign w_b_raw = (w_y4 != 4'd0) ? r_top_buf[w_x4] : INVALID_MODE;
    assign w_a     = (w_a_raw == INVALID_MODE) ? MODE_DC : w_a_raw;
    assign w_b     = (w_b_raw == INVALID_MODE) ? MODE_DC : w_b_raw;

    posi_mpm_derive u_mpm_derive (
        .i_mode_a (w_a),
        .i_mode_b (w_b),
        .o_cand0  (w_cand0),
        .o_cand1  (w_cand1),
        .o_cand2  (w_cand2)
    );

    always_comb begin
        w_lo = (r_cand0 <= r_cand1) ? r_cand0 : r_cand1;
        w_hi = (r_cand0 <= r_cand1) ? r_cand1 : r_cand0;
        if (r_cand2 >= w_hi) begin
            w_s0 = w_lo;
            w_s1 = w_hi;
            w_s2 = r_cand2;
        end else if (r_cand2 >= w_lo) begin
            w_s0 = w_lo;
            w_s1 = r_cand2;
            w_s2 = w_hi;
        end else begin
            w_s0 = r_cand2;
            w_s1 = w_lo;
            w_s2 = w_hi;
        end
    end

    // Remaining-mode index skips over the three candidates in ascending order
    assign w_m0 = {1'b0, r_rem};
    assign w_m1 = w_m0 + {5'd0, (w_m0 >= r_s0)};
    assign w_m2 = w_m1 + {5'd0, (w_m1 >= r_s1)};
    assign w_m3 = w_m2 + {5'd0, (w_m2 >= r_s2)};

    always_comb begin
        case (r_idx)
            2'd0:    w_sel = r_cand0;
            2'd1:    w_sel = r_cand1;
            default: w_sel = r_cand2;
        endcase
    end

    assign w_mode_dec = r_flag ? w_sel : w_m3;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_size  <= 2'd0;
            r_pos   <= 8'd0;
            r_flag  <= 1'b0;
            r_idx   <= 2'd0;
            r_rem   <= 5'd0;
            r_cand0 <= 6'd0;
            r_cand1 <= 6'd0;
            r_cand2 <= 6'd0;
            r_s0    <= 6'd0;
            r_s1    <= 6'd0;
            r_s2    <= 6'd0;
            r_mode  <= 6'd0;
        end else begin
            if (w_accept) begin
                r_size <= size_i;
                r_pos  <= position_i;
                r_flag <= mpm_flag_i;
                r_idx  <= mpm_idx_i;
                r_rem  <= rem_mode_i;
            end
            if (r_state == ST_CAND) begin
                r_cand0 <= w_cand0;
                r_cand1 <= w_cand1;
                r_cand2 <= w_cand2;
            end
            if (r_state == ST_SORT) begin
                r_s0 <= w_s0;
                r_s1 <= w_s1;
                r_s2 <= w_s2;
            end
            if (r_state == ST_ADJ) begin
                r_mode <= w_mode_dec;
            end
        end
    end

    always_comb begin
        w_in_x = 16'd0;
        w_in_y = 16'd0;
        for (int i = 0; i < 16; i++) begin
            w_in_x[i] = (5'(i) >= {1'b0, w_x4}) && (5'(i) < ({1'b0, w_x4} + w_n));
            w_in_y[i] = (5'(i) >= {1'b0, w_y4}) && (5'(i) < ({1'b0, w_y4} + w_n));
        end
    end

    // Start clears only in IDLE, so it never collides with the OUT-state write
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < 16; i++) begin
                r_top_buf[i] <= INVALID_MODE;
                r_lft_buf[i] <= INVALID_MODE;
            end
        end else if (w_clear) begin
            for (int i = 0; i < 16; i++) begin
                r_top_buf[i] <= INVALID_MODE;
                r_lft_buf[i] <= INVALID_MODE;
            end
        end else if (w_release) begin
            for (int i = 0; i < 16; i++) begin
                if (w_in_x[i]) begin
                    r_top_buf[i] <= r_mode;
                end
                if (w_in_y[i]) begin
                    r_lft_buf[i] <= r_mode;
                end
            end
        end
    end

    assign mode_o     = r_mode;
    assign size_o     = r_size;
    assign position_o = r_pos;

endmodule

// File: tb/tb_posi_intra_mode_dec.sv
// tb/tb_posi_intra_mode_dec.sv - self-checking bench for posi_intra_mode_dec
module tb_posi_intra_mode_dec;
    import posi_intra_mode_dec_pkg::*;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       start_i = 1'b0;
    logic       val_i = 1'b0;
    logic       rdy_o;
    logic [1:0] size_i = 2'd0;
    logic [7:0] position_i = 8'd0;
    logic       mpm_flag_i = 1'b0;
    logic [1:0] mpm_idx_i = 2'd0;
    logic [4:0] rem_mode_i = 5'd0;
    logic       val_o;
    logic       rdy_i = 1'b0;
    logic [5:0] mode_o;
    logic [1:0] size_o;
    logic [7:0] position_o;

    int n_tests = 0;
    int n_fail  = 0;

    int m_top [16];
    int m_lft [16];

    int d_got, d_size, d_pos, d_exp, d_lat;
    bit d_to, d_stable;

    posi_intra_mode_dec dut (
        .clk        (clk),
        .rstn       (rstn),
        .start_i    (start_i),
        .val_i      (val_i),
        .rdy_o      (rdy_o),
        .size_i     (size_i),
        .position_i (position_i),
        .mpm_flag_i (mpm_flag_i),
        .mpm_idx_i  (mpm_idx_i),
        .rem_mode_i (rem_mode_i),
        .val_o      (val_o),
        .rdy_i      (rdy_i),
        .mode_o     (mode_o),
        .size_o     (size_o),
        .position_o (position_o)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic int xcoord(int pos);
        return ((pos >> 0) & 1) | (((pos >> 2) & 1) << 1) | (((pos >> 4) & 1) << 2) | (((pos >> 6) & 1) << 3);
    endfunction

    function automatic int ycoord(int pos);
        return ((pos >> 1) & 1) | (((pos >> 3) & 1) << 1) | (((pos >> 5) & 1) << 2) | (((pos >> 7) & 1) << 3);
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < 16; i++) begin
            m_top[i] = 63;
            m_lft[i] = 63;
        end
    endfunction

    function automatic void model_write(int pos, int sz, int mode);
        int n;
        n = 1 << sz;
        for (int i = 0; i < n; i++) begin
            m_top[xcoord(pos) + i] = mode;
            m_lft[ycoord(pos) + i] = mode;
        end
    endfunction

    function automatic int ref_mode(int pos, int flg, int idx, int rem);
        int a, b, c0, c1, c2, m;
        int q[$];
        a = (xcoord(pos) != 0) ? m_lft[ycoord(pos)] : 63;
        b = (ycoord(pos) != 0) ? m_top[xcoord(pos)] : 63;
        if (a == 63) a = 1;
        if (b == 63) b = 1;
        if (a == b) begin
            if (a < 2) begin
                c0 = 0; c1 = 1; c2 = 26;
            end else begin
                c0 = a;
                c1 = 2 + ((a + 29) % 32);
                c2 = 2 + ((a - 1) % 32);
            end
        end else begin
            c0 = a;
            c1 = b;
            if (a != 0 && b != 0) c2 = 0;
            else if (a != 1 && b != 1) c2 = 1;
            else c2 = 26;
        end
        if (flg != 0) begin
            if (idx == 0) return c0;
            if (idx == 1) return c1;
            return c2;
        end
        q = {c0, c1, c2};
        q.sort();
        m = rem;
        for (int k = 0; k < 3; k++) begin
            if (m >= q[k]) m++;
        end
        return m;
    endfunction

    task automatic run_block(input int st, input int sz, input int pos, input int flg,
                             input int idx, input int rem, input int hold);
        int w;
        int first_mode;
        d_to = 1'b0;
        d_lat = 0;
        d_got = -1;
        d_stable = 1'b1;
        if (st != 0) model_clear();
        d_exp = ref_mode(pos, flg, idx, rem);
        @(negedge clk);
        w = 0;
        while (!rdy_o && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (!rdy_o) begin
            d_to = 1'b1;
            return;
        end
        start_i    = (st != 0);
        val_i      = 1'b1;
        size_i     = sz[1:0];
        position_i = pos[7:0];
        mpm_flag_i = (flg != 0);
        mpm_idx_i  = idx[1:0];
        rem_mode_i = rem[4:0];
        @(posedge clk);
        #1;
        val_i   = 1'b0;
        start_i = 1'b0;
        while (!val_o && d_lat < 20) begin
            @(posedge clk);
            #1;
            d_lat++;
        end
        if (!val_o) begin
            d_to = 1'b1;
            return;
        end
        first_mode = mode_o;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            if (!val_o || rdy_o || mode_o != first_mode[5:0]) d_stable = 1'b0;
        end
        @(negedge clk);
        d_got  = mode_o;
        d_size = size_o;
        d_pos  = position_o;
        rdy_i  = 1'b1;
        @(posedge clk);
        #1;
        rdy_i = 1'b0;
        model_write(pos, sz, d_exp);
    endtask

    task automatic decode_as(input int st, input int sz, input int pos, input int target);
        int flg, idx, rem;
        bit found;
        found = 1'b0;
        flg = 0; idx = 0; rem = 0;
        if (st != 0) model_clear();
        for (int r = 0; r < 32 && !found; r++) begin
            if (ref_mode(pos, 0, 0, r) == target) begin
                found = 1'b1; flg = 0; rem = r;
            end
        end
        for (int i = 0; i < 3 && !found; i++) begin
            if (ref_mode(pos, 1, i, 0) == target) begin
                found = 1'b1; flg = 1; idx = i;
            end
        end
        run_block(st, sz, pos, flg, idx, rem, 0);
        n_tests++;
        if (d_to || d_got !== target) begin
            n_fail++;
            $display("FAIL setup_decode pos=%0h: got %0d, expected %0d (timeout=%0d)", pos, d_got, target, d_to);
        end
    endtask

    task automatic setup3(input int mode);
        decode_as(1, 1, 8'h00, mode);
        decode_as(0, 1, 8'h04, mode);
        decode_as(0, 1, 8'h08, mode);
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_clear();
        n_tests++;
        if (rdy_o !== 1'b1) begin n_fail++; $display("FAIL reset_rdy: got %0b, expected 1", rdy_o); end
        n_tests++;
        if (val_o !== 1'b0) begin n_fail++; $display("FAIL reset_val: got %0b, expected 0", val_o); end
        n_tests++;
        if (mode_o !== 6'd0) begin n_fail++; $display("FAIL reset_mode: got %0d, expected 0", mode_o); end
        n_tests++;
        if (size_o !== 2'd0 || position_o !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_size_pos: got %0d/%0h, expected 0/0", size_o, position_o);
        end
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic test_empty();
        run_block(1, SIZE_08, 8'h00, 1, 0, 0, 0);
        n_tests++;
        if (d_to || d_got !== 0) begin n_fail++; $display("FAIL empty_idx0: got %0d, expected 0", d_got); end
        n_tests++;
        if (d_lat !== 3) begin n_fail++; $display("FAIL latency: got %0d edges after accept, expected 3", d_lat); end
        run_block(0, SIZE_08, 8'h00, 1, 2, 0, 0);
        n_tests++;
        if (d_to || d_got !== 26) begin n_fail++; $display("FAIL empty_idx2: got %0d, expected 26", d_got); end
        n_tests++;
        if (d_lat !== 3) begin n_fail++; $display("FAIL latency_flag1: got %0d edges after accept, expected 3", d_lat); end
    endtask

    task automatic test_rem_empty();
        int rems [4] = '{0, 8, 24, 31};
        int exps [4] = '{2, 10, 27, 34};
        for (int i = 0; i < 4; i++) begin
            run_block(i == 0, SIZE_08, 8'h00, 0, 0, rems[i], 0);
            n_tests++;
            if (d_to || d_got !== exps[i]) begin
                n_fail++;
                $display("FAIL rem_empty rem=%0d: got %0d, expected %0d", rems[i], d_got, exps[i]);
            end
        end
    endtask

    task automatic test_a_ne_b();
        int flgs [3] = '{1, 1, 0};
        int idxs [3] = '{0, 2, 0};
        int exps [3] = '{10, 0, 2};
        for (int i = 0; i < 3; i++) begin
            decode_as(1, SIZE_08, 8'h00, 10);
            run_block(0, SIZE_08, 8'h04, flgs[i], idxs[i], 0, 0);
            n_tests++;
            if (d_to || d_got !== exps[i]) begin
                n_fail++;
                $display("FAIL a_ne_b case %0d: got %0d, expected %0d", i, d_got, exps[i]);
            end
        end
    endtask

    task automatic test_a_eq_b();
        int exps [2] = '{9, 11};
        for (int i = 0; i < 2; i++) begin
            setup3(10);
            run_block(0, SIZE_08, 8'h0C, 1, i + 1, 0, 0);
            n_tests++;
            if (d_to || d_got !== exps[i]) begin
                n_fail++;
                $display("FAIL a_eq_b idx=%0d: got %0d, expected %0d", i + 1, d_got, exps[i]);
            end
        end
    endtask

    task automatic test_wrap();
        int modes [2] = '{2, 34};
        int lists [2][3] = '{'{2, 33, 3}, '{34, 33, 3}};
        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < 3; i++) begin
                setup3(modes[m]);
                run_block(0, SIZE_08, 8'h0C, 1, i, 0, 0);
                n_tests++;
                if (d_to || d_got !== lists[m][i]) begin
                    n_fail++;
                    $display("FAIL wrap mode=%0d idx=%0d: got %0d, expected %0d", modes[m], i, d_got, lists[m][i]);
                end
            end
        end
        setup3(2);
        run_block(0, SIZE_08, 8'h0C, 0, 0, 31, 0);
        n_tests++;
        if (d_to || d_got !== 34) begin n_fail++; $display("FAIL wrap_rem31: got %0d, expected 34", d_got); end
        run_block(0, SIZE_08, 8'h0C, 1, 3, 0, 0);
        n_tests++;
        if (d_to || d_got !== 3) begin n_fail++; $display("FAIL illegal_idx3: got %0d, expected 3", d_got); end
    endtask

    task automatic test_backpressure();
        run_block(1, SIZE_08, 8'h00, 1, 2, 0, 3);
        n_tests++;
        if (!d_stable) begin n_fail++; $display("FAIL backpressure_stable: outputs changed while held, expected stable"); end
        n_tests++;
        if (d_to || d_got !== 26) begin n_fail++; $display("FAIL backpressure_mode: got %0d, expected 26", d_got); end
        run_block(0, SIZE_08, 8'h04, 1, 0, 0, 0);
        n_tests++;
        if (d_to || d_got !== 26) begin n_fail++; $display("FAIL after_backpressure: got %0d, expected 26", d_got); end
    endtask

    task automatic test_reset_mid();
        decode_as(1, SIZE_16, 8'h00, 10);
        @(negedge clk);
        val_i      = 1'b1;
        size_i     = SIZE_08;
        position_i = 8'h0C;
        mpm_flag_i = 1'b1;
        mpm_idx_i  = 2'd2;
        @(posedge clk);
        #1;
        val_i = 1'b0;
        @(posedge clk);
        #1;
        rstn = 1'b0;
        #1;
        model_clear();
        n_tests++;
        if (val_o !== 1'b0 || rdy_o !== 1'b1 || mode_o !== 6'd0) begin
            n_fail++;
            $display("FAIL reset_mid: got val=%0b rdy=%0b mode=%0d, expected 0/1/0", val_o, rdy_o, mode_o);
        end
        @(negedge clk);
        rstn = 1'b1;
        run_block(0, SIZE_08, 8'h0C, 1, 2, 0, 0);
        n_tests++;
        if (d_to || d_got !== 26) begin n_fail++; $display("FAIL reset_mid_neigh: got %0d, expected 26", d_got); end
    endtask

    task automatic test_random();
        int sz, n, x4, y4, pos, st, flg, idx, rem, hold;
        for (int t = 0; t < 60; t++) begin
            sz = $urandom_range(0, 3);
            n  = 1 << sz;
            x4 = $urandom_range(0, 16 / n - 1) * n;
            y4 = $urandom_range(0, 16 / n - 1) * n;
            pos = 0;
            for (int b = 0; b < 4; b++) begin
                pos |= ((x4 >> b) & 1) << (2 * b);
                pos |= ((y4 >> b) & 1) << (2 * b + 1);
            end
            st   = (t == 0 || $urandom_range(0, 7) == 0) ? 1 : 0;
            flg  = $urandom_range(0, 1);
            idx  = $urandom_range(0, 3);
            rem  = $urandom_range(0, 31);
            hold = $urandom_range(0, 2);
            run_block(st, sz, pos, flg, idx, rem, hold);
            n_tests++;
            if (d_to || d_got !== d_exp) begin
                n_fail++;
                $display("FAIL random_mode t=%0d pos=%0h sz=%0d: got %0d, expected %0d", t, pos, sz, d_got, d_exp);
            end
            n_tests++;
            if (d_size !== sz || d_pos !== pos || !d_stable || d_lat !== 3) begin
                n_fail++;
                $display("FAIL random_meta t=%0d: got size=%0d pos=%0h stable=%0b lat=%0d, expected %0d/%0h/1/3",
                         t, d_size, d_pos, d_stable, d_lat, sz, pos);
            end
        end
    endtask

    initial begin
        test_reset();
        test_empty();
        test_rem_empty();
        test_a_ne_b();
        test_a_eq_b();
        test_wrap();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
